// File: rtl/instr_type.sv
// Decoded instruction kinds shared between the decoder and the execution units.
package instr_type;

  typedef enum logic [3:0] {
    sysk_invalid = 4'd0,
    sysk_csrrw   = 4'd1,
    sysk_csrrs   = 4'd2,
    sysk_csrrc   = 4'd3,
    sysk_csrrwi  = 4'd4,
    sysk_csrrsi  = 4'd5,
    sysk_csrrci  = 4'd6,
    sysk_ecall   = 4'd7,
    sysk_ebreak  = 4'd8
  } system_kind_t;

endpackage

// File: rtl/system_exec_ctrl_pkg.sv
// Shared constants, controller state type and kind-classification helpers for system_exec_ctrl.
package system_exec_ctrl_pkg;
  import instr_type::*;

  typedef enum logic [2:0] {
    StIdle,
    StCsrRd,
    StCsrWr,
    StTrapEpc,
    StTrapCause,
    StTrapVec,
    StFin
  } sys_ctrl_state_t;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;

  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

  function automatic logic is_csr_kind(system_kind_t k);
    case (k)
      sysk_csrrw, sysk_csrrs, sysk_csrrc,
      sysk_csrrwi, sysk_csrrsi, sysk_csrrci: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_kind(system_kind_t k);
    return (k == sysk_csrrwi) || (k == sysk_csrrsi) || (k == sysk_csrrci);
  endfunction

  function automatic logic is_rw_kind(system_kind_t k);
    return (k == sysk_csrrw) || (k == sysk_csrrwi);
  endfunction

  function automatic logic is_trap_kind(system_kind_t k);
    return (k == sysk_ecall) || (k == sysk_ebreak);
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational CSR read-modify-write: derives the new CSR value and whether a write is needed.
module csr_rmw_alu
  import instr_type::*;
(
  input  system_kind_t kind_i,
  input  logic [31:0]  old_i,
  input  logic [31:0]  src_i,
  input  logic         src_idx_zero_i,
  output logic [31:0]  new_o,
  output logic         write_en_o
);

  always_comb begin
    new_o      = old_i;
    write_en_o = 1'b0;
    case (kind_i)
      sysk_csrrw, sysk_csrrwi: begin
        new_o      = src_i;
        write_en_o = 1'b1;
      end
      // Set/clear with a zero source field must not produce a write side effect.
      sysk_csrrs, sysk_csrrsi: begin
        new_o      = old_i | src_i;
        write_en_o = ~src_idx_zero_i;
      end
      sysk_csrrc, sysk_csrrci: begin
        new_o      = old_i & ~src_i;
        write_en_o = ~src_idx_zero_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/system_exec_ctrl.sv
// Executes decoded system instructions (CSR accesses, ecall/ebreak traps) over a CSR-file port.
module system_exec_ctrl
  import instr_type::*;
  import system_exec_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  system_kind_t kind,
  input  logic [11:0]  csr_addr_in,
  input  logic [31:0]  rs1_val,
  input  logic [4:0]   rs1_idx,
  input  logic [4:0]   rd,
  input  logic [31:0]  pc,
  output logic         csr_req,
  output logic         csr_we,
  output logic [11:0]  csr_addr,
  output logic [31:0]  csr_wdata,
  input  logic [31:0]  csr_rdata,
  input  logic         csr_ack,
  output logic         rd_we,
  output logic [4:0]   rd_addr,
  output logic [31:0]  rd_wdata,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic         done,
  output logic         illegal
);

  sys_ctrl_state_t state_q, state_d;
  system_kind_t    kind_q, kind_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     pc_q, pc_d;
  // Holds the old CSR value for CSR kinds, or mtvec for traps.
  logic [31:0]     data_q, data_d;
  logic [4:0]      rd_q, rd_d;
  logic            idx_zero_q, idx_zero_d;

  logic [31:0]     new_val;
  logic            rmw_we;

  csr_rmw_alu u_rmw (
    .kind_i         (kind_q),
    .old_i          (data_q),
    .src_i          (src_q),
    .src_idx_zero_i (idx_zero_q),
    .new_o          (new_val),
    .write_en_o     (rmw_we)
  );

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    addr_d         = addr_q;
    src_d          = src_q;
    pc_d           = pc_q;
    data_d         = data_q;
    rd_d           = rd_q;
    idx_zero_d     = idx_zero_q;
    req_ready      = 1'b0;
    csr_req        = 1'b0;
    csr_we         = 1'b0;
    csr_addr       = 12'h0;
    csr_wdata      = 32'h0;
    rd_we          = 1'b0;
    rd_addr        = 5'd0;
    rd_wdata       = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    done           = 1'b0;
    illegal        = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          kind_d     = kind;
          addr_d     = csr_addr_in;
          src_d      = is_imm_kind(kind) ? {27'b0, rs1_idx} : rs1_val;
          idx_zero_d = (rs1_idx == 5'd0);
          rd_d       = rd;
          pc_d       = pc;
          data_d     = 32'h0;
          if (is_csr_kind(kind)) begin
            // A swap into x0 has no observable read, so the read is skipped entirely.
            state_d = (is_rw_kind(kind) && rd == 5'd0) ? StCsrWr : StCsrRd;
          end else if (is_trap_kind(kind)) begin
            state_d = StTrapEpc;
          end else begin
            state_d = StFin;
          end
        end
      end
      StCsrRd: begin
        csr_req  = 1'b1;
        csr_addr = addr_q;
        if (csr_ack) begin
          data_d  = csr_rdata;
          state_d = rmw_we ? StCsrWr : StFin;
        end
      end
      StCsrWr: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = addr_q;
        csr_wdata = new_val;
        if (csr_ack) state_d = StFin;
      end
      StTrapEpc: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
        if (csr_ack) state_d = StTrapCause;
      end
      StTrapCause: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = (kind_q == sysk_ebreak) ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
        if (csr_ack) state_d = StTrapVec;
      end
      StTrapVec: begin
        csr_req  = 1'b1;
        csr_addr = CSR_MTVEC;
        if (csr_ack) begin
          data_d  = csr_rdata;
          state_d = StFin;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
        if (is_csr_kind(kind_q)) begin
          if (rd_q != 5'd0) begin
            rd_we    = 1'b1;
            rd_addr  = rd_q;
            rd_wdata = data_q;
          end
        end else if (is_trap_kind(kind_q)) begin
          redirect_valid = 1'b1;
          redirect_pc    = {data_q[31:2], 2'b00};
        end else begin
          illegal = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      kind_q     <= sysk_invalid;
      addr_q     <= 12'h0;
      src_q      <= 32'h0;
      pc_q       <= 32'h0;
      data_q     <= 32'h0;
      rd_q       <= 5'd0;
      idx_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      pc_q       <= pc_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      idx_zero_q <= idx_zero_d;
    end
  end

endmodule

// File: tb/tb_system_exec_ctrl.sv
// Randomized bench for system_exec_ctrl: CSR-file responder plus transaction-level reference model.
module tb_system_exec_ctrl;
  import instr_type::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  system_kind_t kind;
  logic [11:0]  csr_addr_in;
  logic [31:0]  rs1_val;
  logic [4:0]   rs1_idx;
  logic [4:0]   rd;
  logic [31:0]  pc;
  logic         csr_req;
  logic         csr_we;
  logic [11:0]  csr_addr;
  logic [31:0]  csr_wdata;
  logic [31:0]  csr_rdata;
  logic         csr_ack;
  logic         rd_we;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_wdata;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         done;
  logic         illegal;

  always #5 clk = ~clk;

  system_exec_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .kind           (kind),
    .csr_addr_in    (csr_addr_in),
    .rs1_val        (rs1_val),
    .rs1_idx        (rs1_idx),
    .rd             (rd),
    .pc             (pc),
    .csr_req        (csr_req),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_ack        (csr_ack),
    .rd_we          (rd_we),
    .rd_addr        (rd_addr),
    .rd_wdata       (rd_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .done           (done),
    .illegal        (illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [4096];

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full transaction; fixed_dly >= 0 forces that ack delay on every access, else random.
  task automatic run_txn(input system_kind_t k, input logic [11:0] a, input logic [31:0] v,
                         input logic [4:0] idx, input logic [4:0] r, input logic [31:0] p,
                         input int fixed_dly);
    logic [31:0] src, old, nv, e_rdw, e_redir;
    logic        e_rdwe, e_redir_v, e_ill;
    int          op, cyc, exp_cyc, wait_n, dly;
    bit          in_acc, got_done;
    acc_t        cur;

    exp_q.delete();
    e_rdwe = 1'b0; e_redir_v = 1'b0; e_ill = 1'b0; e_rdw = 32'h0; e_redir = 32'h0;
    case (k)
      sysk_csrrw, sysk_csrrs, sysk_csrrc, sysk_csrrwi, sysk_csrrsi, sysk_csrrci: begin
        src = (k == sysk_csrrwi || k == sysk_csrrsi || k == sysk_csrrci) ? {27'b0, idx} : v;
        old = mem[a];
        op  = (k == sysk_csrrw || k == sysk_csrrwi) ? 0 :
              (k == sysk_csrrs || k == sysk_csrrsi) ? 1 : 2;
        nv  = (op == 0) ? src : (op == 1) ? (old | src) : (old & ~src);
        if (!(op == 0 && r == 5'd0)) exp_q.push_back(acc_t'{we: 1'b0, addr: a, wdata: 32'h0});
        if (op == 0 || idx != 5'd0)  exp_q.push_back(acc_t'{we: 1'b1, addr: a, wdata: nv});
        e_rdwe = (r != 5'd0);
        e_rdw  = old;
      end
      sysk_ecall, sysk_ebreak: begin
        exp_q.push_back(acc_t'{we: 1'b1, addr: 12'h341, wdata: p});
        exp_q.push_back(acc_t'{we: 1'b1, addr: 12'h342,
                               wdata: (k == sysk_ecall) ? 32'd11 : 32'd3});
        exp_q.push_back(acc_t'{we: 1'b0, addr: 12'h305, wdata: 32'h0});
        e_redir_v = 1'b1;
        e_redir   = mem[12'h305] & ~32'h3;
      end
      default: e_ill = 1'b1;
    endcase

    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; kind = k; csr_addr_in = a; rs1_val = v; rs1_idx = idx; rd = r; pc = p;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the DUT must work from its latched copy.
    req_valid   = 1'b0;
    kind        = system_kind_t'($urandom_range(0, 8));
    csr_addr_in = 12'($urandom);
    rs1_val     = $urandom;
    rs1_idx     = 5'($urandom);
    rd          = 5'($urandom);
    pc          = $urandom;

    cyc = 0; exp_cyc = 1; wait_n = 0; dly = 0; in_acc = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
        csr_ack  = 1'b0;
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("accesses_left", 32'(exp_q.size()), 32'd0);
        check("fin_csr_req", 32'(csr_req), 32'd0);
        check("fin_rd_we", 32'(rd_we), 32'(e_rdwe));
        if (e_rdwe) begin
          check("fin_rd_addr", 32'(rd_addr), 32'(r));
          check("fin_rd_wdata", rd_wdata, e_rdw);
        end
        check("fin_redirect_valid", 32'(redirect_valid), 32'(e_redir_v));
        if (e_redir_v) check("fin_redirect_pc", redirect_pc, e_redir);
        check("fin_illegal", 32'(illegal), 32'(e_ill));
      end else begin
        check("busy_pulses_low", {29'b0, rd_we, redirect_valid, illegal}, 32'd0);
        if (csr_req) begin
          if (exp_q.size() == 0) begin
            check("unexpected_access", 32'(csr_req), 32'd0);
            csr_ack = 1'b0;
          end else begin
            cur = exp_q[0];
            if (!in_acc) begin
              in_acc  = 1'b1;
              wait_n  = 0;
              dly     = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
              exp_cyc += dly + 1;
            end
            check("acc_we", 32'(csr_we), 32'(cur.we));
            check("acc_addr", 32'(csr_addr), 32'(cur.addr));
            if (cur.we) check("acc_wdata", csr_wdata, cur.wdata);
            if (wait_n == dly) begin
              csr_ack   = 1'b1;
              csr_rdata = cur.we ? $urandom : mem[cur.addr];
              if (cur.we) mem[cur.addr] = cur.wdata;
              void'(exp_q.pop_front());
              in_acc = 1'b0;
            end else begin
              csr_ack = 1'b0;
              wait_n++;
            end
          end
        end else begin
          // Stray acks with no request outstanding must be ignored.
          csr_ack   = ($urandom_range(0, 3) == 0);
          csr_rdata = $urandom;
        end
      end
    end
    if (!got_done) begin
      check("timeout_waiting_done", 32'(done), 32'd1);
    end else begin
      @(negedge clk);
      check("done_single_cycle", 32'(done), 32'd0);
      check("ready_after_fin", 32'(req_ready), 32'd1);
    end
  endtask

  system_kind_t kinds [9] = '{sysk_invalid, sysk_csrrw, sysk_csrrs, sysk_csrrc, sysk_csrrwi,
                              sysk_csrrsi, sysk_csrrci, sysk_ecall, sysk_ebreak};
  logic [11:0]  addrs [6] = '{12'h340, 12'h300, 12'h304, 12'h305, 12'h7C0, 12'hB00};

  initial begin
    bit got_wr;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    rst = 1'b0; req_valid = 1'b0; kind = sysk_invalid; csr_addr_in = 12'h0; rs1_val = 32'h0;
    rs1_idx = 5'd0; rd = 5'd0; pc = 32'h0; csr_rdata = 32'h0; csr_ack = 1'b0;

    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_csr_req", 32'(csr_req), 32'd0);
    check("rst_csr_we", 32'(csr_we), 32'd0);
    check("rst_csr_addr", 32'(csr_addr), 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_pulses", {27'b0, rd_we, redirect_valid, done, illegal, 1'b0}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    mem[12'h340] = 32'h1234_5678;
    run_txn(sysk_csrrw, 12'h340, 32'hDEAD_BEEF, 5'd7, 5'd5, 32'h0, 0);
    mem[12'h300] = 32'h0000_0088;
    run_txn(sysk_csrrs, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd3, 32'h0, 1);
    mem[12'h304] = 32'h0000_000F;
    run_txn(sysk_csrrci, 12'h304, 32'h0, 5'h08, 5'd1, 32'h0, 0);
    mem[12'h305] = 32'h8000_0103;
    run_txn(sysk_ecall, 12'h000, 32'h0, 5'd0, 5'd0, 32'h8000_0010, 0);
    run_txn(sysk_ebreak, 12'h000, 32'h0, 5'd0, 5'd0, 32'h8000_0044, -1);
    run_txn(sysk_invalid, 12'h000, 32'h0, 5'd0, 5'd9, 32'h0, 0);
    run_txn(sysk_csrrw, 12'h7C0, 32'h0F0F_0F0F, 5'd2, 5'd0, 32'h0, 5);
    run_txn(sysk_csrrc, 12'h340, 32'h0000_FFFF, 5'd4, 5'd8, 32'h0, 5);

    // Reset asserted while a write is waiting for its ack.
    @(negedge clk);
    req_valid = 1'b1; kind = sysk_csrrw; csr_addr_in = 12'h340; rs1_val = 32'hCAFE_F00D;
    rs1_idx = 5'd6; rd = 5'd5; pc = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_wr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (csr_req && csr_we) begin
        got_wr = 1'b1;
        break;
      end
      csr_ack   = csr_req;
      csr_rdata = 32'h0BAD_F00D;
    end
    csr_ack = 1'b0;
    check("midrst_reached_write", 32'(got_wr), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_csr_req", 32'(csr_req), 32'd0);
    check("midrst_csr_we", 32'(csr_we), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done | rd_we), 32'd0);
    end
    rst = 1'b1;
    run_txn(sysk_csrrw, 12'h340, 32'h5555_AAAA, 5'd6, 5'd5, 32'h0, -1);

    for (int n = 0; n < 200; n++) begin
      run_txn(kinds[$urandom_range(0, 8)], addrs[$urandom_range(0, 5)], $urandom,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              $urandom, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
